// File: rtl/rob_alloc.sv
// rob_alloc: dispatch-side reorder-buffer allocator.
// Hands out ROB numbers in program order from a circular tail pointer,
// tracks occupancy from retire notifications and stalls dispatch when
// the whole request group does not fit.
module rob_alloc #(
    parameter int ROB_DEPTH = 16,
    parameter int PTR_W     = 4,
    parameter int PREG_W    = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic [1:0]            i_req_valid,
    input  logic [2*PREG_W-1:0]   i_preg_dst,
    input  logic [2*PREG_W-1:0]   i_old_preg_dst,
    input  logic [1:0]            i_regwrite,
    input  logic [1:0]            i_memwrite,
    input  logic [1:0]            i_retire_valid,
    output logic                  o_stall,
    output logic [1:0]            o_rob_valid,
    output logic [2*PTR_W-1:0]    o_rob_num,
    output logic [2*PREG_W-1:0]   o_rob_preg_dst,
    output logic [2*PREG_W-1:0]   o_rob_old_preg_dst,
    output logic [1:0]            o_rob_regwrite,
    output logic [1:0]            o_rob_memwrite,
    output logic [PTR_W:0]        o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(ROB_DEPTH);

    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head;
    logic [PTR_W:0]   count;

    logic [1:0]       req_n;
    logic [1:0]       ret_n;
    logic [PTR_W:0]   req_ext;
    logic [PTR_W:0]   ret_ext;
    logic [PTR_W:0]   free;
    logic             fits;
    logic             accept;
    logic [1:0]       alloc_n;
    logic [PTR_W:0]   ret_eff;
    logic             src0;

    // Request/retire counts, free space and the all-or-nothing accept decision
    always_comb begin
        req_n   = {1'b0, i_req_valid[0]} + {1'b0, i_req_valid[1]};
        ret_n   = {1'b0, i_retire_valid[0]} + {1'b0, i_retire_valid[1]};
        req_ext = {{(PTR_W-1){1'b0}}, req_n};
        ret_ext = {{(PTR_W-1){1'b0}}, ret_n};
        free    = DEPTH_C - count;
        fits    = (req_ext <= free);
        o_stall = !fits && !i_flush;
        accept  = fits && !i_flush;
        alloc_n = accept ? req_n : 2'd0;
        // Over-retire is a protocol error; clamp so count bottoms out at zero
        ret_eff = (ret_ext > count) ? count : ret_ext;
        // Oldest valid request lands on output slot 0
        src0    = !i_req_valid[0];
    end

    // Pointer/occupancy state and registered ROB-row outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tail               <= '0;
            head               <= '0;
            count              <= '0;
            o_rob_valid        <= '0;
            o_rob_num          <= '0;
            o_rob_preg_dst     <= '0;
            o_rob_old_preg_dst <= '0;
            o_rob_regwrite     <= '0;
            o_rob_memwrite     <= '0;
        end else if (i_flush) begin
            tail        <= '0;
            head        <= '0;
            count       <= '0;
            o_rob_valid <= '0;
        end else begin
            count <= count + {{(PTR_W-1){1'b0}}, alloc_n} - ret_eff;
            head  <= head + ret_eff[PTR_W-1:0];
            tail  <= tail + {{(PTR_W-2){1'b0}}, alloc_n};
            if (alloc_n != 2'd0) begin
                o_rob_valid                        <= (alloc_n == 2'd2) ? 2'b11 : 2'b01;
                o_rob_num[PTR_W-1:0]               <= tail;
                o_rob_preg_dst[PREG_W-1:0]         <= src0 ? i_preg_dst[2*PREG_W-1:PREG_W]
                                                           : i_preg_dst[PREG_W-1:0];
                o_rob_old_preg_dst[PREG_W-1:0]     <= src0 ? i_old_preg_dst[2*PREG_W-1:PREG_W]
                                                           : i_old_preg_dst[PREG_W-1:0];
                o_rob_regwrite[0]                  <= i_regwrite[src0];
                o_rob_memwrite[0]                  <= i_memwrite[src0];
                if (alloc_n == 2'd2) begin
                    o_rob_num[2*PTR_W-1:PTR_W]         <= tail + PTR_W'(1);
                    o_rob_preg_dst[2*PREG_W-1:PREG_W]  <= i_preg_dst[2*PREG_W-1:PREG_W];
                    o_rob_old_preg_dst[2*PREG_W-1:PREG_W] <= i_old_preg_dst[2*PREG_W-1:PREG_W];
                    o_rob_regwrite[1]                  <= i_regwrite[1];
                    o_rob_memwrite[1]                  <= i_memwrite[1];
                end
            end else begin
                o_rob_valid <= '0;
            end
        end
    end

    // Occupancy status flags
    always_comb begin
        o_count = count;
        o_full  = (count == DEPTH_C);
        o_empty = (count == '0);
    end

    // Retiring more rows than are occupied indicates a broken retire stage
    retire_le_count: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !i_flush |-> (ret_ext <= count))
        else $error("rob_alloc: retire count exceeds occupancy");

endmodule

// File: tb/tb_rob_alloc.sv
// tb_rob_alloc: scoreboard bench for rob_alloc with a queue-based reference model.
module tb_rob_alloc;

    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int GW    = 6;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_flush = 1'b0;
    logic [1:0]        i_req_valid = '0;
    logic [2*GW-1:0]   i_preg_dst = '0;
    logic [2*GW-1:0]   i_old_preg_dst = '0;
    logic [1:0]        i_regwrite = '0;
    logic [1:0]        i_memwrite = '0;
    logic [1:0]        i_retire_valid = '0;
    logic              o_stall;
    logic [1:0]        o_rob_valid;
    logic [2*PW-1:0]   o_rob_num;
    logic [2*GW-1:0]   o_rob_preg_dst;
    logic [2*GW-1:0]   o_rob_old_preg_dst;
    logic [1:0]        o_rob_regwrite;
    logic [1:0]        o_rob_memwrite;
    logic [PW:0]       o_count;
    logic              o_full;
    logic              o_empty;

    rob_alloc #(.ROB_DEPTH(DEPTH), .PTR_W(PW), .PREG_W(GW)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_flush            (i_flush),
        .i_req_valid        (i_req_valid),
        .i_preg_dst         (i_preg_dst),
        .i_old_preg_dst     (i_old_preg_dst),
        .i_regwrite         (i_regwrite),
        .i_memwrite         (i_memwrite),
        .i_retire_valid     (i_retire_valid),
        .o_stall            (o_stall),
        .o_rob_valid        (o_rob_valid),
        .o_rob_num          (o_rob_num),
        .o_rob_preg_dst     (o_rob_preg_dst),
        .o_rob_old_preg_dst (o_rob_old_preg_dst),
        .o_rob_regwrite     (o_rob_regwrite),
        .o_rob_memwrite     (o_rob_memwrite),
        .o_count            (o_count),
        .o_full             (o_full),
        .o_empty            (o_empty)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int n_ent;
        int num[2];
        int preg[2];
        int oldp[2];
        int rw[2];
        int mw[2];
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference state: occupancy and next ROB number
    int m_count = 0;
    int m_tail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // one dispatch cycle: drive, check combinational/occupancy outputs, update model
    task automatic step(input logic [1:0] req, input logic [1:0] ret, input logic fl);
        int req_n, ret_n, idx[$];
        bit stall;
        exp_t e;
        @(posedge i_clk);
        #1;
        i_req_valid    = req;
        i_retire_valid = ret;
        i_flush        = fl;
        i_preg_dst     = 12'($urandom);
        i_old_preg_dst = 12'($urandom);
        i_regwrite     = 2'($urandom);
        i_memwrite     = 2'($urandom);
        #1;
        req_n = $countones(req);
        ret_n = $countones(ret);
        stall = !fl && (req_n > DEPTH - m_count);
        chk("count", int'(o_count), m_count);
        chk("full", int'(o_full), int'(m_count == DEPTH));
        chk("empty", int'(o_empty), int'(m_count == 0));
        chk("stall", int'(o_stall), int'(stall));
        if (fl) begin
            m_count = 0;
            m_tail  = 0;
        end else begin
            if (!stall && req_n > 0) begin
                for (int s = 0; s < 2; s++) if (req[s]) idx.push_back(s);
                e.cyc   = cyc + 1;
                e.n_ent = req_n;
                for (int k = 0; k < req_n; k++) begin
                    e.num[k]  = (m_tail + k) % DEPTH;
                    e.preg[k] = int'((i_preg_dst >> (GW * idx[k])) & 12'h3f);
                    e.oldp[k] = int'((i_old_preg_dst >> (GW * idx[k])) & 12'h3f);
                    e.rw[k]   = int'(i_regwrite[idx[k]]);
                    e.mw[k]   = int'(i_memwrite[idx[k]]);
                end
                exp_q.push_back(e);
                m_tail  = (m_tail + req_n) % DEPTH;
                m_count = m_count + req_n;
            end
            m_count = m_count - ret_n;
        end
    endtask

    // monitor: pop and compare whenever the DUT presents a ROB row
    always @(negedge i_clk) begin
        if (i_rst_n && o_rob_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", int'(o_rob_valid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", cyc, e.cyc);
                chk("valid", int'(o_rob_valid), (e.n_ent == 2) ? 3 : 1);
                for (int k = 0; k < e.n_ent; k++) begin
                    chk("num", int'((o_rob_num >> (PW * k)) & 8'hf), e.num[k]);
                    chk("preg", int'((o_rob_preg_dst >> (GW * k)) & 12'h3f), e.preg[k]);
                    chk("old_preg", int'((o_rob_old_preg_dst >> (GW * k)) & 12'h3f), e.oldp[k]);
                    chk("regwrite", int'(o_rob_regwrite[k]), e.rw[k]);
                    chk("memwrite", int'(o_rob_memwrite[k]), e.mw[k]);
                end
            end
        end
    end

    initial begin
        logic [1:0] r, q;
        #1;
        chk("rst_valid", int'(o_rob_valid), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_num", int'(o_rob_num), 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // first group after reset
        step(2'b11, 2'b00, 1'b0);
        // move tail to 5, then a lone slot-1 request
        step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b11, 1'b0);
        step(2'b10, 2'b01, 1'b0);

        // fill to 15, stall on a pair, accept a single, full + retire stall
        step(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 7; i++) step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b11, 1'b0);
        step(2'b01, 2'b00, 1'b0);

        // wrap-around at tail 15
        step(2'b00, 2'b00, 1'b1);
        step(2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) step(2'b11, 2'b11, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b0);

        // flush at count 9 with requests present
        step(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b01, 1'b1);
        step(2'b01, 2'b00, 1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            q = 2'($urandom);
            r = 2'($urandom);
            if ($countones(r) > m_count) r = 2'b00;
            step(q, r, ($urandom_range(0, 39) == 0));
        end

        // asynchronous reset mid-burst
        step(2'b11, 2'b00, 1'b0);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(o_rob_valid), 0);
        chk("async_rst_count", int'(o_count), 0);
        chk("async_rst_num", int'(o_rob_num), 0);
        exp_q.delete();
        m_count = 0;
        m_tail  = 0;
        i_req_valid    = '0;
        i_retire_valid = '0;
        i_flush        = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(2'b01, 2'b00, 1'b0);

        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b0);
        @(posedge i_clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
